// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider with pipeline-stall control (IDLE/CALC/FIX/DONE).
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             res_valid,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] pr_q, pr_d, wq_q, wq_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  logic signed [WIDTH-1:0] dvd_s, dvs_s;
  logic                    dvd_neg, dvs_neg;
  logic [WIDTH-1:0]        dvd_mag, dvs_mag;
  logic [WIDTH:0]          shifted, diff;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  always_comb begin
    dvd_s   = dividend;
    dvs_s   = divisor;
    dvd_neg = op_signed && (dvd_s < 0);
    dvs_neg = op_signed && (dvs_s < 0);
    dvd_mag = dvd_neg ? negate(dividend) : dividend;
    dvs_mag = dvs_neg ? negate(divisor) : divisor;
    // WIDTH+1 bits so the divisor magnitude 2^(WIDTH-1) and the shifted remainder never overflow
    shifted = {pr_q, wq_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    pr_d    = pr_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
            dvs_d  = dvs_mag;
            wq_d   = dvd_mag;
            pr_d   = '0;
            if (divisor == '0) begin
              state_d = DONE;
              quot_d  = '1;
              rem_d   = dividend;
              dbz_d   = 1'b1;
            end else begin
              state_d = CALC;
              cnt_d   = CNT_W'(WIDTH);
              dbz_d   = 1'b0;
`ifdef DIV_EARLY_OUT_EN
              if (dvd_mag < dvs_mag) begin
                state_d = DONE;
                cnt_d   = '0;
                quot_d  = '0;
                rem_d   = dividend;
              end
`else
`endif
            end
          end
        end
        CALC: begin
          if (diff[WIDTH]) begin
            pr_d = shifted[WIDTH-1:0];
            wq_d = {wq_q[WIDTH-2:0], 1'b0};
          end else begin
            pr_d = diff[WIDTH-1:0];
            wq_d = {wq_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
        FIX: begin
          // Results are committed to quot/rem here so they hold across later operations
          quot_d  = qneg_q ? negate(wq_q) : wq_q;
          rem_d   = rneg_q ? negate(pr_q) : pr_q;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    pr_q   <= pr_d;
    wq_q   <= wq_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign stall       = op_valid & ~flush & (state_q != DONE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE) & ~flush;
  assign div_by_zero = res_valid & dbz_q;
  assign quot        = quot_q;
  assign rem         = rem_q;

endmodule
